// File: rtl/sect233r1_pkg.sv
// sect233r1 field constants, checker FSM encoding and GF(2^233) helpers.
// Latency: n/a (package: constants and combinational functions only).
// Backpressure: n/a.
//
// Field: GF(2^233), f(z) = z^233 + z^74 + 1. Curve b and generator (GX, GY)
// for sect233r1. gf_sqr is the single-cycle squarer used when
// SECT233R1_PT_CHK_SQR_EN is defined.
package sect233r1_pkg;

    localparam int POLY_T0 = 233;
    localparam int POLY_T1 = 74;
    localparam int POLY_T2 = 0;
    localparam int M       = POLY_T0;

    localparam logic [M-1:0] B  = 233'h066_647EDE6C_332C7F8C_0923BB58_213B333B_20E9CE42_81FE115F_7D8F90AD;
    localparam logic [M-1:0] GX = 233'h0FA_C9DFCBAC_8313BB21_39F1BB75_5FEF65BC_391F8B36_F8F8EB73_71FD558B;
    localparam logic [M-1:0] GY = 233'h100_6A08A419_03350678_E58528BE_BF8A0BEF_F867A7CA_36716F7E_01F81052;

    localparam logic [M-1:0] ONE   = {{(M-1){1'b0}}, 1'b1};
    // Low-order part of f: what z^233 folds back into.
    localparam logic [M-1:0] F_LOW = (ONE << POLY_T1) | (ONE << POLY_T2);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL1 = 3'd1,
        ST_MUL2 = 3'd2,
        ST_MUL3 = 3'd3,
        ST_CMP  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // a * z mod f
    function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? F_LOW : '0);
    endfunction

    // a^2 mod f: squaring in characteristic 2 just spreads the bits, then the
    // top half is folded down from the highest bit so cascaded folds land on
    // bits not yet visited.
    function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] a);
        logic [2*M-2:0] s;
        s = '0;
        for (int i = 0; i < M; i++) begin
            s[2*i] = a[i];
        end
        for (int j = 2*M-2; j >= M; j--) begin
            if (s[j]) begin
                s[j]                     = 1'b0;
                s[j-POLY_T0+POLY_T2]     = ~s[j-POLY_T0+POLY_T2];
                s[j-POLY_T0+POLY_T1]     = ~s[j-POLY_T0+POLY_T1];
            end
        end
        return s[M-1:0];
    endfunction

endpackage

// File: rtl/sect233r1_gf_mul.sv
// Digit-serial MSB-first GF(2^233) multiplier, p = a*b mod f.
// Latency: N = ceil(233/DIGIT) edges; the start edge already performs digit 1.
// Backpressure: none; a start while running restarts the product.
//
// Ports: clk, rst (sync, active-high); start (1-cycle, samples a/b);
// done (1-cycle pulse, p valid from then until the next start); p (result).
module sect233r1_gf_mul
    import sect233r1_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         done,
    output logic [M-1:0] p
);

    localparam int N    = (M + DIGIT - 1) / DIGIT;
    localparam int PADW = N * DIGIT;
    localparam int CW   = $clog2(N + 1);

    logic [M-1:0]    a_q, a_d;
    logic [PADW-1:0] b_q, b_d;
    logic [M-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d;
    logic            done_q, done_d;
    logic [PADW-1:0] b_pad;

    // acc*z^DIGIT + a*d, reduced after every bit so the accumulator never
    // grows past 233 bits.
    function automatic logic [M-1:0] step(input logic [M-1:0] acc,
                                          input logic [M-1:0] op,
                                          input logic [DIGIT-1:0] d);
        logic [M-1:0] r;
        r = acc;
        for (int i = DIGIT-1; i >= 0; i--) begin
            r = gf_xtime(r) ^ (d[i] ? op : '0);
        end
        return r;
    endfunction

    always_comb begin
        // Pad above the MSB so the partial digit carries only leading zeros and
        // the product value is unchanged.
        b_pad         = '0;
        b_pad[M-1:0]  = b;

        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;

        if (start) begin
            a_d    = a;
            acc_d  = step('0, a, b_pad[PADW-1 -: DIGIT]);
            b_d    = b_pad << DIGIT;
            cnt_d  = CW'(N - 1);
            run_d  = (N > 1);
            done_d = (N == 1);
        end else if (run_q) begin
            acc_d = step(acc_q, a_q, b_q[PADW-1 -: DIGIT]);
            b_d   = b_q << DIGIT;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign p    = acc_q;

endmodule

// File: rtl/sect233r1_pt_chk.sv
// sect233r1 point-validity checker: y^2 + xy == x^3 + x^2 + b, plus (0,0) flag.
// Latency: done the cycle after edge k+3N+2 (k+2N+3 with SECT233R1_PT_CHK_SQR_EN).
// Backpressure: none; start is ignored outside IDLE.
//
// Ports: clk; rst/clr (sync, active-high, abort and clear everything);
// start + x/y (request, sampled in IDLE); busy, done (1-cycle pulse),
// on_curve, is_inf (held until the next accepted start).
// Macro SECT233R1_PT_CHK_SQR_EN: x^2 by a combinational squarer instead of the
// shared multiplier; results are identical either way.
module sect233r1_pt_chk
    import sect233r1_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         start,
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    output logic         busy,
    output logic         done,
    output logic         on_curve,
    output logic         is_inf
);

    state_e       state_q, state_d;
    logic [M-1:0] xr_q, xr_d;
    logic [M-1:0] yr_q, yr_d;
    logic [M-1:0] t1_q, t1_d;
    logic [M-1:0] t2_q, t2_d;
    logic [M-1:0] t3_q, t3_d;
    logic         first_q, first_d;
    logic         on_curve_q, on_curve_d;
    logic         is_inf_q, is_inf_d;

    logic         srst;
    logic         mul_start;
    logic [M-1:0] mul_a;
    logic [M-1:0] mul_b;
    logic         mul_done;
    logic [M-1:0] mul_p;

    assign srst = rst | clr;

    sect233r1_gf_mul #(.DIGIT(DIGIT)) u_mul (
        .clk   (clk),
        .rst   (srst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .done  (mul_done),
        .p     (mul_p)
    );

    // Products are chained: the cycle a product completes, the next one is
    // launched straight from the multiplier output, so no idle cycle is spent
    // between MUL states. first_q marks the one state-entry that has no
    // preceding product to chain from.
    always_comb begin
        state_d    = state_q;
        xr_d       = xr_q;
        yr_d       = yr_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        t3_d       = t3_q;
        first_d    = 1'b0;
        on_curve_d = on_curve_q;
        is_inf_d   = is_inf_q;
        mul_start  = 1'b0;
        mul_a      = yr_q;
        mul_b      = yr_q ^ xr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    xr_d       = x;
                    yr_d       = y;
                    on_curve_d = 1'b0;
                    is_inf_d   = 1'b0;
                    first_d    = 1'b1;
                    state_d    = ST_MUL1;
                end
            end
            ST_MUL1: begin
`ifdef SECT233R1_PT_CHK_SQR_EN
                t2_d    = gf_sqr(xr_q);
                first_d = 1'b1;
                state_d = ST_MUL2;
`else
                if (first_q) begin
                    mul_start = 1'b1;
                    mul_a     = xr_q;
                    mul_b     = xr_q;
                end else if (mul_done) begin
                    t2_d      = mul_p;
                    mul_start = 1'b1;
                    mul_a     = mul_p;
                    mul_b     = xr_q ^ ONE;
                    state_d   = ST_MUL2;
                end
`endif
            end
            ST_MUL2: begin
                if (first_q) begin
                    mul_start = 1'b1;
                    mul_a     = t2_q;
                    mul_b     = xr_q ^ ONE;
                end else if (mul_done) begin
                    t3_d      = mul_p;
                    mul_start = 1'b1;
                    mul_a     = yr_q;
                    mul_b     = yr_q ^ xr_q;
                    state_d   = ST_MUL3;
                end
            end
            ST_MUL3: begin
                if (mul_done) begin
                    t1_d    = mul_p;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                on_curve_d = (t1_q == (t3_q ^ B));
                is_inf_d   = (xr_q == '0) && (yr_q == '0);
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            xr_q       <= '0;
            yr_q       <= '0;
            t1_q       <= '0;
            t2_q       <= '0;
            t3_q       <= '0;
            first_q    <= 1'b0;
            on_curve_q <= 1'b0;
            is_inf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            xr_q       <= xr_d;
            yr_q       <= yr_d;
            t1_q       <= t1_d;
            t2_q       <= t2_d;
            t3_q       <= t3_d;
            first_q    <= first_d;
            on_curve_q <= on_curve_d;
            is_inf_q   <= is_inf_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign on_curve = on_curve_q;
    assign is_inf   = is_inf_q;

endmodule

// File: tb/tb_sect233r1_pt_chk.sv
// Directed bench for sect233r1_pt_chk (default build, DIGIT = 8).
// Latency: n/a. Backpressure: n/a.
module tb_sect233r1_pt_chk;
    import sect233r1_pkg::*;

    localparam int DIGIT = 8;
    localparam int N     = 30;
    localparam int LAT   = 3*N + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         start;
    logic [M-1:0] x;
    logic [M-1:0] y;
    logic         busy;
    logic         done;
    logic         on_curve;
    logic         is_inf;

    int n_chk  = 0;
    int n_fail = 0;

    logic [M-1:0] y_bad;
    logic [M-1:0] sqrt_b;
    int           ndone;
    int           d1_c, d2_c;
    logic         d1_oc, d2_oc;

    always #5 clk = ~clk;

    sect233r1_pt_chk #(.DIGIT(DIGIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .start    (start),
        .x        (x),
        .y        (y),
        .busy     (busy),
        .done     (done),
        .on_curve (on_curve),
        .is_inf   (is_inf)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Schoolbook product then fold with f = z^233 + z^74 + 1.
    function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-2:0] pr;
        logic [2*M-2:0] aw;
        pr = '0;
        aw = '0;
        aw[M-1:0] = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) pr = pr ^ (aw << i);
        end
        for (int j = 2*M-2; j >= 233; j--) begin
            if (pr[j]) begin
                pr[j]       = 1'b0;
                pr[j-233]   = ~pr[j-233];
                pr[j-159]   = ~pr[j-159];
            end
        end
        return pr[M-1:0];
    endfunction

    // One request: checks busy, latency, flags, and the one-cycle done.
    task automatic run_point(input string tag, input logic [M-1:0] px, input logic [M-1:0] py,
                             input logic exp_on, input logic exp_inf);
        int  lat;
        logic got;
        @(negedge clk);
        x = px; y = py; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x = ~px; y = ~py;
        chk1({tag, "_busy"}, busy, 1'b1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) got = 1'b1;
        end
        chkn({tag, "_lat"}, lat, LAT);
        chk1({tag, "_on_curve"}, on_curve, exp_on);
        chk1({tag, "_is_inf"}, is_inf, exp_inf);
        @(posedge clk);
        #1;
        chk1({tag, "_done_fall"}, done, 1'b0);
        chk1({tag, "_busy_fall"}, busy, 1'b0);
        chk1({tag, "_on_curve_held"}, on_curve, exp_on);
    endtask

    // Abort mid-operation with rst (use_clr = 0) or clr (use_clr = 1).
    task automatic run_abort(input string tag, input logic use_clr);
        int nd;
        @(negedge clk);
        x = GX; y = GY; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c < 40; c++) begin
            @(posedge clk);
            #1;
        end
        chk1({tag, "_busy_before"}, busy, 1'b1);
        if (use_clr) clr = 1'b1; else rst = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        rst = 1'b0;
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_on_curve"}, on_curve, 1'b0);
        chk1({tag, "_is_inf"}, is_inf, 1'b0);
        nd = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chkn({tag, "_no_done"}, nd, 0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; start = 1'b0; x = '0; y = '0;
        y_bad = GY ^ {{(M-1){1'b0}}, 1'b1};
        sqrt_b = B;
        for (int i = 0; i < 232; i++) sqrt_b = ref_mul(sqrt_b, sqrt_b);

        repeat (3) @(posedge clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_on_curve", on_curve, 1'b0);
        chk1("rst_is_inf", is_inf, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_point("gen",    GX, GY,     1'b1, 1'b0);
        run_point("bad_y",  GX, y_bad,  1'b0, 1'b0);
        run_point("inf",    '0, '0,     1'b0, 1'b1);
        run_point("order2", '0, sqrt_b, 1'b1, 1'b0);

        // Back-to-back: stray starts at k+5 and in the done cycle, then the
        // real second request on the first edge back in IDLE.
        @(negedge clk);
        x = GX; y = GY; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0; d1_c = 0; d2_c = 0; d1_oc = 1'b0; d2_oc = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            start = (c == 5) || (c == LAT + 1) || (c == LAT + 2);
            x = GX;
            y = (c == LAT + 1) ? GY : y_bad;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin d1_c = c; d1_oc = on_curve; end
                if (ndone == 2) begin d2_c = c; d2_oc = on_curve; end
            end
        end
        chkn("b2b_ndone", ndone, 2);
        chkn("b2b_done1_cycle", d1_c, LAT);
        chk1("b2b_done1_on_curve", d1_oc, 1'b1);
        chkn("b2b_done2_cycle", d2_c, 2*LAT + 2);
        chk1("b2b_done2_on_curve", d2_oc, 1'b0);

        run_abort("abort_rst", 1'b0);
        run_abort("abort_clr", 1'b1);

        // clr wins over a simultaneous start.
        @(negedge clk);
        x = GX; y = GY; start = 1'b1; clr = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; clr = 1'b0;
        chk1("clr_vs_start_busy", busy, 1'b0);

        run_point("gen_again", GX, GY, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
